// File: rtl/mux_n_pipe.sv
// N:1 word-select mux built as a tree of 2:1 levels, with registered,
// valid-tagged output, optional mid-tree register, stall and flush.
module mux_n_pipe #(
  parameter int WIDTH   = 16,
  parameter int NUM_IN  = 8,
  parameter int SEL_W   = 3,
  parameter int LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        s,
  input  logic                    E,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out,
  output logic                    out_valid,
  output logic                    sel_err
);

  localparam int HI = SEL_W / 2;
  localparam int LO = SEL_W - HI;
  localparam int NL = 1 << SEL_W;
  localparam int NP = 1 << HI;
  localparam int HW = (HI > 0) ? HI : 1;
  localparam logic [SEL_W:0] LIMIT = (SEL_W + 1)'(NUM_IN);

  // Lower LO levels; leaves past NUM_IN read as zero, which also
  // makes out-of-range selects yield zero data.
  function automatic logic [NP*WIDTH-1:0] reduce_lo(
    input logic [NUM_IN*WIDTH-1:0] d,
    input logic [LO-1:0]           sel
  );
    logic [NL*WIDTH-1:0] t;
    t = '0;
    t[NUM_IN*WIDTH-1:0] = d;
    for (int j = 0; j < LO; j++) begin
      for (int i = 0; i < (NL >> (j + 1)); i++) begin
        t[i*WIDTH +: WIDTH] = sel[j] ? t[(2*i+1)*WIDTH +: WIDTH]
                                     : t[(2*i)*WIDTH +: WIDTH];
      end
    end
    return t[NP*WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] reduce_hi(
    input logic [NP*WIDTH-1:0] p,
    input logic [HW-1:0]       sh
  );
    logic [NP*WIDTH-1:0] t;
    t = p;
    for (int j = 0; j < HI; j++) begin
      for (int i = 0; i < (NP >> (j + 1)); i++) begin
        t[i*WIDTH +: WIDTH] = sh[j] ? t[(2*i+1)*WIDTH +: WIDTH]
                                    : t[(2*i)*WIDTH +: WIDTH];
      end
    end
    return t[WIDTH-1:0];
  endfunction

  logic [NP*WIDTH-1:0] part;
  logic [HW-1:0]       s_hi;
  logic                oor;

  assign part = reduce_lo(in_bus, s[LO-1:0]);
  assign s_hi = s[SEL_W-1 -: HW];
  assign oor  = ({1'b0, s} >= LIMIT);

  if (LATENCY == 1) begin : g_l1
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out       <= '0;
        out_valid <= 1'b0;
        sel_err   <= 1'b0;
      end else if (flush) begin
        out_valid <= 1'b0;
        sel_err   <= 1'b0;
      end else if (!stall) begin
        out       <= E ? reduce_hi(part, s_hi) : '0;
        out_valid <= in_valid;
        sel_err   <= in_valid & E & oor;
      end
    end
  end else begin : g_l2
    logic [NP*WIDTH-1:0] part_a;
    logic [HW-1:0]       s_hi_a;
    logic                e_a;
    logic                err_a;
    logic                v_a;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        part_a <= '0;
        s_hi_a <= '0;
        e_a    <= 1'b0;
        err_a  <= 1'b0;
        v_a    <= 1'b0;
      end else if (flush) begin
        err_a  <= 1'b0;
        v_a    <= 1'b0;
      end else if (!stall) begin
        part_a <= part;
        s_hi_a <= s_hi;
        e_a    <= E;
        err_a  <= E & oor;
        v_a    <= in_valid;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        out       <= '0;
        out_valid <= 1'b0;
        sel_err   <= 1'b0;
      end else if (flush) begin
        out_valid <= 1'b0;
        sel_err   <= 1'b0;
      end else if (!stall) begin
        out       <= e_a ? reduce_hi(part_a, s_hi_a) : '0;
        out_valid <= v_a;
        sel_err   <= v_a & err_a;
      end
    end
  end

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed bench for mux_n_pipe across four configurations
// sharing clock and control inputs.
module tb_mux_n_pipe;

  logic       clk;
  logic       rst;
  logic [2:0] s;
  logic       E;
  logic       in_valid;
  logic       stall;
  logic       flush;

  logic [8*16-1:0] bus_a;
  logic [6*16-1:0] bus_b;
  logic [3*32-1:0] bus_d;

  logic [15:0] out_a, out_b, out_c;
  logic [31:0] out_d;
  logic        v_a, v_b, v_c, v_d;
  logic        e_a, e_b, e_c, e_d;

  int checks = 0;
  int errors = 0;

  mux_n_pipe #(.WIDTH(16), .NUM_IN(8), .SEL_W(3), .LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .in_bus(bus_a), .s(s), .E(E),
    .in_valid(in_valid), .stall(stall), .flush(flush),
    .out(out_a), .out_valid(v_a), .sel_err(e_a));

  mux_n_pipe #(.WIDTH(16), .NUM_IN(6), .SEL_W(3), .LATENCY(1)) dut_b (
    .clk(clk), .rst(rst), .in_bus(bus_b), .s(s), .E(E),
    .in_valid(in_valid), .stall(stall), .flush(flush),
    .out(out_b), .out_valid(v_b), .sel_err(e_b));

  mux_n_pipe #(.WIDTH(16), .NUM_IN(8), .SEL_W(3), .LATENCY(2)) dut_c (
    .clk(clk), .rst(rst), .in_bus(bus_a), .s(s), .E(E),
    .in_valid(in_valid), .stall(stall), .flush(flush),
    .out(out_c), .out_valid(v_c), .sel_err(e_c));

  mux_n_pipe #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .LATENCY(2)) dut_d (
    .clk(clk), .rst(rst), .in_bus(bus_d), .s(s[1:0]), .E(E),
    .in_valid(in_valid), .stall(stall), .flush(flush),
    .out(out_d), .out_valid(v_d), .sel_err(e_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 8; k++) bus_a[k*16 +: 16] = 16'h1000 + 16'(k);
    for (int k = 0; k < 6; k++) bus_b[k*16 +: 16] = 16'h2000 + 16'(k);
    bus_d = {32'hFFFFFFFF, 32'h00000000, 32'hDEADBEEF};
    rst = 1'b1; s = '0; E = 1'b0; in_valid = 1'b0;
    stall = 1'b0; flush = 1'b0;

    #2;
    chk("rst_out",   32'(out_a), 32'h0);
    chk("rst_valid", 32'(v_a),   32'h0);
    chk("rst_err",   32'(e_a),   32'h0);
    chk("rst_c_val", 32'(v_c),   32'h0);

    @(negedge clk);
    rst = 1'b0;

    // basic selection sweep
    E = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      s = 3'(k);
      tick();
      chk("sweep_out", 32'(out_a), 32'h1000 + 32'(k));
      chk("sweep_val", 32'(v_a), 32'h1);
      chk("sweep_err", 32'(e_a), 32'h0);
    end

    // enable and out-of-range, six inputs
    s = 3'd5; tick();
    chk("b_s5_out", 32'(out_b), 32'h2005);
    chk("b_s5_err", 32'(e_b),   32'h0);
    s = 3'd6; tick();
    chk("b_s6_out", 32'(out_b), 32'h0);
    chk("b_s6_err", 32'(e_b),   32'h1);
    s = 3'd7; tick();
    chk("b_s7_out", 32'(out_b), 32'h0);
    chk("b_s7_err", 32'(e_b),   32'h1);
    E = 1'b0; tick();
    chk("b_e0_out", 32'(out_b), 32'h0);
    chk("b_e0_err", 32'(e_b),   32'h0);
    chk("b_e0_val", 32'(v_b),   32'h1);
    E = 1'b1; s = 3'd2; tick();
    chk("b_s2_out", 32'(out_b), 32'h2002);

    // pipelined stream with stall
    in_valid = 1'b0; tick(); tick();
    chk("c_idle", 32'(v_c), 32'h0);
    in_valid = 1'b1; s = 3'd3; tick();
    chk("c_lat1", 32'(v_c), 32'h0);
    s = 3'd1; tick();
    chk("c_t3_out", 32'(out_c), 32'h1003);
    chk("c_t3_val", 32'(v_c),   32'h1);
    s = 3'd7; stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("c_stall_out", 32'(out_c), 32'h1003);
      chk("c_stall_val", 32'(v_c),   32'h1);
    end
    stall = 1'b0; tick();
    chk("c_t1_out", 32'(out_c), 32'h1001);
    s = 3'd0; tick();
    chk("c_t7_out", 32'(out_c), 32'h1007);
    in_valid = 1'b0; tick();
    chk("c_t0_out", 32'(out_c), 32'h1000);
    chk("c_t0_val", 32'(v_c),   32'h1);
    tick();
    chk("c_drain", 32'(v_c), 32'h0);

    // flush with stall, two tokens in flight
    in_valid = 1'b1; s = 3'd2; tick();
    s = 3'd4; tick();
    chk("f_pre_out", 32'(out_c), 32'h1002);
    s = 3'd5; flush = 1'b1; stall = 1'b1; tick();
    chk("f_val1", 32'(v_c), 32'h0);
    chk("f_err1", 32'(e_c), 32'h0);
    flush = 1'b0; stall = 1'b0; s = 3'd6; tick();
    chk("f_val2", 32'(v_c), 32'h0);
    in_valid = 1'b0; tick();
    chk("f_new_out", 32'(out_c), 32'h1006);
    chk("f_new_val", 32'(v_c),   32'h1);
    tick();
    chk("f_after", 32'(v_c), 32'h0);

    // asynchronous reset away from the clock edge
    in_valid = 1'b1; s = 3'd3; tick();
    chk("r_pre_out", 32'(out_a), 32'h1003);
    chk("r_pre_val", 32'(v_a),   32'h1);
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    chk("r_out",   32'(out_a), 32'h0);
    chk("r_val",   32'(v_a),   32'h0);
    chk("r_err",   32'(e_a),   32'h0);
    chk("r_c_val", 32'(v_c),   32'h0);
    tick();
    chk("r_hold", 32'(v_a), 32'h0);
    #3 rst = 1'b0;
    tick();
    chk("r_idle", 32'(v_a), 32'h0);
    in_valid = 1'b1; s = 3'd2; tick();
    chk("r_new_out", 32'(out_a), 32'h1002);
    chk("r_new_val", 32'(v_a),   32'h1);

    // wide three-input configuration
    in_valid = 1'b0; tick(); tick();
    in_valid = 1'b1; s = 3'd2; tick();
    chk("d_lat1", 32'(v_d), 32'h0);
    s = 3'd3; tick();
    chk("d_s2_out", out_d,      32'hFFFFFFFF);
    chk("d_s2_val", 32'(v_d),   32'h1);
    chk("d_s2_err", 32'(e_d),   32'h0);
    in_valid = 1'b0; tick();
    chk("d_s3_out", out_d,      32'h0);
    chk("d_s3_err", 32'(e_d),   32'h1);
    chk("d_s3_val", 32'(v_d),   32'h1);
    tick();
    chk("d_end_val", 32'(v_d), 32'h0);
    chk("d_end_err", 32'(e_d), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
